// File: rtl/heap_pkg.sv
// Shared types and index helpers for the register-based min-heap.
package heap_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SIFT_UP   = 2'd1,
    ST_SIFT_DOWN = 2'd2
  } state_e;

  function automatic int unsigned parent_idx(input int unsigned i);
    return (i - 1) / 2;
  endfunction

  function automatic int unsigned left_idx(input int unsigned i);
    return 2 * i + 1;
  endfunction

  function automatic int unsigned right_idx(input int unsigned i);
    return 2 * i + 2;
  endfunction
endpackage

// File: rtl/heap_min_sel.sv
// Picks the smaller valid child (left on ties) and flags a strict-less swap.
module heap_min_sel #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] node,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             left_vld,
  input  logic             right_vld,
  output logic             swap,
  output logic             sel_right
);
  logic [WIDTH-1:0] child;

  assign sel_right = right_vld && (right < left);
  assign child     = sel_right ? right : left;
  assign swap      = left_vld && (child < node);
endmodule

// File: rtl/heap_extract.sv
// Binary min-heap in flops: single push/pop front end, one sift step per cycle.
module heap_extract
  import heap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             top_valid,
  output logic             busy,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);
  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            idx_q, idx_d, count_q, count_d, tgt;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  int unsigned idx_i, cnt_i, par_i, lc_i, rc_i, tgt_i;
  logic [WIDTH-1:0] node, left, right;
  logic             lv, rv, swap, sel_right, done;

  assign idx_i = 32'(idx_q);
  assign cnt_i = 32'(count_q);
  assign par_i = parent_idx(idx_i);
  assign lc_i  = left_idx(idx_i);
  assign rc_i  = right_idx(idx_i);

  // Sift-up reuses the child selector: parent acts as node, idx as the lone child.
  always_comb begin
    node  = '0;
    left  = '0;
    right = '0;
    lv    = 1'b0;
    rv    = 1'b0;
    if (state_q == ST_SIFT_UP) begin
      lv   = (idx_q != '0);
      node = lv ? mem_q[CNT_W'(par_i)] : '0;
      left = mem_q[idx_q];
    end else begin
      lv    = (lc_i < cnt_i);
      rv    = (rc_i < cnt_i);
      node  = mem_q[idx_q];
      left  = lv ? mem_q[CNT_W'(lc_i)] : '0;
      right = rv ? mem_q[CNT_W'(rc_i)] : '0;
    end
  end

  heap_min_sel #(.WIDTH(WIDTH)) u_min_sel (
    .node      (node),
    .left      (left),
    .right     (right),
    .left_vld  (lv),
    .right_vld (rv),
    .swap      (swap),
    .sel_right (sel_right)
  );

  assign tgt_i = (state_q == ST_SIFT_UP) ? par_i : (sel_right ? rc_i : lc_i);
  assign tgt   = CNT_W'(tgt_i);
  // Stop on the swap edge itself when the new position cannot move further.
  assign done  = (state_q == ST_SIFT_UP) ? (tgt_i == 0) : (left_idx(tgt_i) >= cnt_i);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    mem_d   = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (push && pop && !empty) begin
          mem_d[0] = push_data;
          idx_d    = '0;
          state_d  = ST_SIFT_DOWN;
        end else if (push && !full) begin
          mem_d[count_q] = push_data;
          idx_d          = count_q;
          count_d        = count_q + 1'b1;
          if (!empty) state_d = ST_SIFT_UP;
        end else if (pop && !push && !empty) begin
          mem_d[0] = mem_q[count_q - 1'b1];
          count_d  = count_q - 1'b1;
          idx_d    = '0;
          if (count_q > CNT_W'(2)) state_d = ST_SIFT_DOWN;
        end
      end
      ST_SIFT_UP, ST_SIFT_DOWN: begin
        if (swap) begin
          mem_d[idx_q] = mem_q[tgt];
          mem_d[tgt]   = mem_q[idx_q];
          idx_d        = tgt;
          if (done) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign top       = mem_q[0];
  assign top_valid = !empty && !busy;
  assign count     = count_q;
endmodule

// File: tb/tb_heap_extract.sv
// Random and directed push/pop traffic against a queue-based min-heap model.
module tb_heap_extract;
  localparam int WIDTH = 8;
  localparam int DEPTH = 7;
  localparam int CNT_W = 3;

  logic             clk, clr, push, pop;
  logic [WIDTH-1:0] push_data, top;
  logic             top_valid, busy, empty, full;
  logic [CNT_W-1:0] count;

  int errs = 0;
  int checks = 0;
  int mq[$];
  int cyc;

  heap_extract #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .push(push), .push_data(push_data), .pop(pop),
    .top(top), .top_valid(top_valid), .busy(busy), .empty(empty),
    .full(full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mdl_min_pos();
    int p = 0;
    for (int i = 1; i < mq.size(); i++) if (mq[i] < mq[p]) p = i;
    return p;
  endfunction

  task automatic mdl_apply(input logic p, input logic q, input int d);
    if (p && q && mq.size() > 0) begin
      mq.delete(mdl_min_pos());
      mq.push_back(d);
    end else if (p && mq.size() < DEPTH) begin
      mq.push_back(d);
    end else if (q && !p && mq.size() > 0) begin
      mq.delete(mdl_min_pos());
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_empty"}, int'(empty), int'(mq.size() == 0));
    chk({tag, "_full"}, int'(full), int'(mq.size() == DEPTH));
    chk({tag, "_topv"}, int'(top_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_top"}, int'(top), mq[mdl_min_pos()]);
  endtask

  // Present one request, optionally poke a push+pop while busy, wait for idle.
  task automatic req(input logic p, input logic q, input int d, input logic inj,
                     output int ncyc);
    @(negedge clk);
    push = p; pop = q; push_data = WIDTH'(d);
    @(negedge clk);
    mdl_apply(p, q, d);
    ncyc = 0;
    while (busy && ncyc < 20) begin
      if (inj && ncyc == 0) begin
        push = 1'b1; pop = 1'b1; push_data = '0;
      end else begin
        push = 1'b0; pop = 1'b0;
      end
      ncyc++;
      @(negedge clk);
    end
    push = 1'b0; pop = 1'b0;
    if (busy) chk("busy_timeout", int'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mq.delete();
  endtask

  initial begin
    clr = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    #12 clr = 1'b0;
    @(negedge clk);
    chk("rst_top", int'(top), 0);
    chk("rst_busy", int'(busy), 0);
    check_state("rst");

    req(1, 0, 5, 0, cyc);
    req(1, 0, 3, 0, cyc);
    req(1, 0, 8, 0, cyc);
    req(1, 0, 1, 0, cyc);
    chk("push1_busy_cycles", cyc, 2);
    check_state("push4");

    for (int i = 0; i < 4; i++) begin
      req(0, 1, 0, 0, cyc);
      check_state("pop4");
    end

    req(0, 1, 0, 0, cyc);
    chk("pop_empty_cycles", cyc, 0);
    check_state("pop_empty");

    req(1, 0, 4, 0, cyc);
    chk("tie4_first_cycles", cyc, 0);
    for (int i = 0; i < 2; i++) begin
      req(1, 0, 4, 0, cyc);
      chk("tie4_cycles", cyc, 1);
    end
    check_state("tie4");
    for (int i = 0; i < 3; i++) req(0, 1, 0, 0, cyc);

    for (int k = 7; k >= 1; k--) req(1, 0, k, 0, cyc);
    check_state("fill");
    req(1, 0, 0, 0, cyc);
    check_state("push_full");
    req(1, 1, 9, 0, cyc);
    check_state("replace");

    req(0, 1, 0, 1, cyc);
    chk("inj_seen_busy", int'(cyc > 0), 1);
    check_state("inject");

    do_reset();
    req(1, 0, 1, 0, cyc);
    req(1, 0, 2, 0, cyc);
    req(1, 0, 3, 0, cyc);
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    chk("clr_pre_busy", int'(busy), 1);
    chk("clr_pre_topv", int'(top_valid), 0);
    #1 clr = 1'b1;
    #1;
    chk("clr_count", int'(count), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_empty", int'(empty), 1);
    @(negedge clk);
    clr = 1'b0;
    mq.delete();
    req(1, 0, 2, 0, cyc);
    check_state("after_clr");

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      req(r <= 4 || r >= 8, r >= 5, $urandom_range(0, 15), $urandom_range(0, 7) == 0, cyc);
      chk("rand_sift_len", int'(cyc <= 2), 1);
      check_state("rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
